rv_lsu: RTL

// Parametrised load/store unit between the RISC-V control unit and the AXI4-Lite BRAM port.

---
 rtl/rv_lsu_pkg.sv | 30 +++
 rtl/rv_lsu_if.sv | 40 ++++
 rtl/rv_lsu_align.sv | 76 +++++++
 rtl/rv_lsu.sv | 183 ++++++++++++++++++
 4 files changed

// File: rtl/rv_lsu_pkg.sv
// Shared types and constants for the RISC-V load/store unit.
// Contents:
//   lsu_state_e  control FSM states
//   lsu_err_e    response error codes reported on rsp_err
//   F3_*         RV32I funct3 encodings for the supported access sizes
package rv_lsu_pkg;

  typedef enum logic [2:0] {
    IDLE,
    RD_ADDR,
    RD_DATA,
    WR,
    WR_RESP,
    RESP
  } lsu_state_e;

  typedef enum logic [1:0] {
    ERR_NONE    = 2'd0,
    ERR_ALIGN   = 2'd1,
    ERR_BUS     = 2'd2,
    ERR_TIMEOUT = 2'd3
  } lsu_err_e;

  localparam logic [2:0] F3_B  = 3'd0;
  localparam logic [2:0] F3_H  = 3'd1;
  localparam logic [2:0] F3_W  = 3'd2;
  localparam logic [2:0] F3_BU = 3'd4;
  localparam logic [2:0] F3_HU = 3'd5;

endpackage

// File: rtl/rv_lsu_if.sv
// AXI4-Lite bus bundle between the load/store unit and the BRAM port.
// Channels: AR (araddr/arvalid/arready), R (rdata/rresp/rvalid/rready),
//           AW (awaddr/awvalid/awready), W (wdata/wstrb/wvalid/wready),
//           B (bresp/bvalid/bready).
// Modports: master = load/store unit side, slave = memory side.
interface rv_lsu_if #(
  parameter int ADDR_W = 20
) ();

  logic [ADDR_W-1:0] araddr;
  logic              arvalid;
  logic              arready;
  logic [31:0]       rdata;
  logic [1:0]        rresp;
  logic              rvalid;
  logic              rready;

  logic [ADDR_W-1:0] awaddr;
  logic              awvalid;
  logic              awready;
  logic [31:0]       wdata;
  logic [3:0]        wstrb;
  logic              wvalid;
  logic              wready;

  logic [1:0]        bresp;
  logic              bvalid;
  logic              bready;

  modport master (
    output araddr, arvalid, rready, awaddr, awvalid, wdata, wstrb, wvalid, bready,
    input  arready, rdata, rresp, rvalid, awready, wready, bresp, bvalid
  );

  modport slave (
    input  araddr, arvalid, rready, awaddr, awvalid, wdata, wstrb, wvalid, bready,
    output arready, rdata, rresp, rvalid, awready, wready, bresp, bvalid
  );

endinterface

// File: rtl/rv_lsu_align.sv
// Combinational data alignment for the load/store unit.
// Ports:
//   we        in   1=store, 0=load (selects which legality check drives bad)
//   funct3    in   RV32I access size/sign
//   addr_lo   in   byte offset within the word
//   store_in  in   raw store value (rs2)
//   rdata     in   raw word read from the bus
//   wdata     out  store value replicated across the byte lanes
//   wstrb     out  byte strobes for the store
//   load_data out  selected lane, sign- or zero-extended
//   bad       out  misaligned access or illegal funct3
module rv_lsu_align
  import rv_lsu_pkg::*;
(
  input  logic        we,
  input  logic [2:0]  funct3,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] store_in,
  input  logic [31:0] rdata,
  output logic [31:0] wdata,
  output logic [3:0]  wstrb,
  output logic [31:0] load_data,
  output logic        bad
);

  logic [7:0]  byte_lane;
  logic [15:0] half_lane;
  logic        st_bad;
  logic        ld_bad;

  assign byte_lane = rdata[{addr_lo, 3'b000} +: 8];
  assign half_lane = rdata[{addr_lo[1], 4'b0000} +: 16];

  // Stores: replicate the value into every lane so the strobe alone picks the target bytes
  always_comb begin
    wdata  = store_in;
    wstrb  = 4'hF;
    st_bad = 1'b0;
    case (funct3)
      F3_B: begin
        wdata = {4{store_in[7:0]}};
        wstrb = 4'b0001 << addr_lo;
      end
      F3_H: begin
        wdata  = {2{store_in[15:0]}};
        wstrb  = 4'b0011 << {addr_lo[1], 1'b0};
        st_bad = addr_lo[0];
      end
      F3_W:    st_bad = (addr_lo != 2'b00);
      default: st_bad = 1'b1;
    endcase
  end

  // Loads: pick the addressed lane and extend it to 32 bits
  always_comb begin
    load_data = rdata;
    ld_bad    = 1'b0;
    case (funct3)
      F3_B:  load_data = {{24{byte_lane[7]}}, byte_lane};
      F3_BU: load_data = {24'd0, byte_lane};
      F3_H: begin
        load_data = {{16{half_lane[15]}}, half_lane};
        ld_bad    = addr_lo[0];
      end
      F3_HU: begin
        load_data = {16'd0, half_lane};
        ld_bad    = addr_lo[0];
      end
      F3_W:    ld_bad = (addr_lo != 2'b00);
      default: ld_bad = 1'b1;
    endcase
  end

  assign bad = we ? st_bad : ld_bad;

endmodule

// File: rtl/rv_lsu.sv
// Load/store unit: takes one request from the control unit, runs the AXI4-Lite
// transaction and returns a one-cycle response.
// Ports:
//   clk, rst      clock, synchronous active-high reset
//   req_*         request (valid/ready, we, funct3, addr, wdata)
//   rsp_valid     one-cycle completion pulse
//   rsp_data      extended load data (0 for stores and errors), held until next response
//   rsp_err       0 ok, 1 misaligned/illegal, 2 bus error, 3 timeout
//   bus           AXI4-Lite master port
module rv_lsu
  import rv_lsu_pkg::*;
#(
  parameter int ADDR_W  = 20,
  parameter int TIMEOUT = 256
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [2:0]        req_funct3,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              rsp_valid,
  output logic [31:0]       rsp_data,
  output logic [1:0]        rsp_err,
  rv_lsu_if.master          bus
);

  localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  lsu_state_e        state;
  logic [2:0]        funct3_q;
  logic [1:0]        addr_lo_q;
  logic [CNT_W-1:0]  wdog;

  logic [2:0]        sel_funct3;
  logic [1:0]        sel_lo;
  logic [31:0]       st_wdata;
  logic [3:0]        st_wstrb;
  logic [31:0]       load_data;
  logic              bad;
  logic              in_bus;
  logic              expired;
  logic              aw_done;
  logic              w_done;

  // The aligner sees the live request while idle (legality + store lanes)
  // and the captured request afterwards (load lane extraction).
  assign sel_funct3 = (state == IDLE) ? req_funct3     : funct3_q;
  assign sel_lo     = (state == IDLE) ? req_addr[1:0]  : addr_lo_q;

  rv_lsu_align u_align (
    .we        (req_we),
    .funct3    (sel_funct3),
    .addr_lo   (sel_lo),
    .store_in  (req_wdata),
    .rdata     (bus.rdata),
    .wdata     (st_wdata),
    .wstrb     (st_wstrb),
    .load_data (load_data),
    .bad       (bad)
  );

  assign in_bus  = (state == RD_ADDR) || (state == RD_DATA) ||
                   (state == WR)      || (state == WR_RESP);
  // The counter holds TIMEOUT-1 in the cycle whose edge would make it reach TIMEOUT
  assign expired = (TIMEOUT != 0) && (wdog == CNT_W'(TIMEOUT - 1));
  assign aw_done = !bus.awvalid || bus.awready;
  assign w_done  = !bus.wvalid  || bus.wready;

  // Control FSM with all outputs registered
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      req_ready   <= 1'b1;
      rsp_valid   <= 1'b0;
      rsp_data    <= '0;
      rsp_err     <= ERR_NONE;
      funct3_q    <= '0;
      addr_lo_q   <= '0;
      wdog        <= '0;
      bus.araddr  <= '0;
      bus.arvalid <= 1'b0;
      bus.rready  <= 1'b0;
      bus.awaddr  <= '0;
      bus.awvalid <= 1'b0;
      bus.wdata   <= '0;
      bus.wstrb   <= '0;
      bus.wvalid  <= 1'b0;
      bus.bready  <= 1'b0;
    end else if (in_bus && expired) begin
      // Hard abort: release every handshake and report a timeout
      bus.arvalid <= 1'b0;
      bus.rready  <= 1'b0;
      bus.awvalid <= 1'b0;
      bus.wvalid  <= 1'b0;
      bus.bready  <= 1'b0;
      state       <= RESP;
      rsp_valid   <= 1'b1;
      rsp_data    <= '0;
      rsp_err     <= ERR_TIMEOUT;
    end else begin
      if (in_bus) wdog <= wdog + 1'b1;
      case (state)
        IDLE: begin
          if (req_valid) begin
            req_ready  <= 1'b0;
            funct3_q   <= req_funct3;
            addr_lo_q  <= req_addr[1:0];
            wdog       <= '0;
            bus.araddr <= {req_addr[ADDR_W-1:2], 2'b00};
            bus.awaddr <= {req_addr[ADDR_W-1:2], 2'b00};
            bus.wdata  <= st_wdata;
            bus.wstrb  <= st_wstrb;
            if (bad) begin
              state     <= RESP;
              rsp_valid <= 1'b1;
              rsp_data  <= '0;
              rsp_err   <= ERR_ALIGN;
            end else if (req_we) begin
              state       <= WR;
              bus.awvalid <= 1'b1;
              bus.wvalid  <= 1'b1;
            end else begin
              state       <= RD_ADDR;
              bus.arvalid <= 1'b1;
            end
          end
        end
        RD_ADDR: begin
          if (bus.arready) begin
            bus.arvalid <= 1'b0;
            bus.rready  <= 1'b1;
            state       <= RD_DATA;
          end
        end
        RD_DATA: begin
          if (bus.rvalid) begin
            bus.rready <= 1'b0;
            state      <= RESP;
            rsp_valid  <= 1'b1;
            if (bus.rresp >= 2'd2) begin
              rsp_data <= '0;
              rsp_err  <= ERR_BUS;
            end else begin
              rsp_data <= load_data;
              rsp_err  <= ERR_NONE;
            end
          end
        end
        WR: begin
          // AW and W complete independently; leave once both have handshaken
          if (bus.awvalid && bus.awready) bus.awvalid <= 1'b0;
          if (bus.wvalid && bus.wready)   bus.wvalid  <= 1'b0;
          if (aw_done && w_done) begin
            bus.bready <= 1'b1;
            state      <= WR_RESP;
          end
        end
        WR_RESP: begin
          if (bus.bvalid) begin
            bus.bready <= 1'b0;
            state      <= RESP;
            rsp_valid  <= 1'b1;
            rsp_data   <= '0;
            rsp_err    <= (bus.bresp >= 2'd2) ? ERR_BUS : ERR_NONE;
          end
        end
        RESP: begin
          rsp_valid <= 1'b0;
          req_ready <= 1'b1;
          state     <= IDLE;
        end
        default: begin
          req_ready <= 1'b1;
          state     <= IDLE;
        end
      endcase
    end
  end

endmodule
